// File: rtl/s386_bist_ctrl_if.sv
// s386_bist_ctrl_if: control/status handshake between test-access logic and the BIST sequencer.
// S386_BIST_SIGOUT_EN adds the sig signature bus.
interface s386_bist_ctrl_if;
    logic start, abort, busy, done, pass;
`ifdef S386_BIST_SIGOUT_EN
    logic [15:0] sig;
    modport master(output start, abort, input busy, done, pass, sig);
    modport slave(input start, abort, output busy, done, pass, sig);
`else
    modport master(output start, abort, input busy, done, pass);
    modport slave(input start, abort, output busy, done, pass);
`endif
endinterface

// File: rtl/s386_bist_ctrl.sv
// s386_bist_ctrl: LFSR-stimulus / MISR-compaction BIST sequencer for the s386 core.
// S386_BIST_SIGOUT_EN exposes the captured MISR signature on ctl.sig.
module s386_bist_ctrl #(
    parameter int unsigned NPAT      = 16,
    parameter int unsigned FLUSH_CYC = 8,
    parameter logic [6:0]  FLUSH_VEC = 7'h00,
    parameter logic [6:0]  SEED      = 7'h01,
    parameter logic [15:0] GOLDEN    = 16'h0000
) (
    input  logic            CK,
    input  logic            RN,
    s386_bist_ctrl_if.slave ctl,
    output logic [6:0]      cut_in,
    input  logic [6:0]      cut_out
);
    localparam logic [6:0]  SEED_NZ    = (SEED == 7'h00) ? 7'h01 : SEED;
    localparam logic [15:0] FLUSH_LAST = 16'(FLUSH_CYC - 1);
    localparam logic [15:0] RUN_LAST   = 16'(NPAT - 1);

    typedef enum logic [2:0] {IDLE, FLUSH, RUN, CMP, DONE} state_t;

    state_t      state;
    logic [6:0]  lfsr;
    logic [15:0] misr, cnt;
    logic [6:0]  lfsr_nxt;
    logic [15:0] misr_nxt;

    assign lfsr_nxt = {lfsr[5:0], lfsr[6] ^ lfsr[5]};
    assign misr_nxt = {misr[14:0], 1'b0} ^ (misr[15] ? 16'h1021 : 16'h0000) ^ {9'b0, cut_out};

    // lfsr always holds the pattern that will be applied next; cut_in holds the current one
    always_ff @(posedge CK or negedge RN) begin
        if (!RN) begin
            state    <= IDLE;
            cut_in   <= FLUSH_VEC;
            lfsr     <= SEED_NZ;
            misr     <= 16'h0000;
            cnt      <= 16'h0000;
            ctl.busy <= 1'b0;
            ctl.done <= 1'b0;
            ctl.pass <= 1'b0;
`ifdef S386_BIST_SIGOUT_EN
            ctl.sig  <= 16'h0000;
`endif
        end else if (ctl.abort && state != IDLE) begin
            state    <= IDLE;
            cut_in   <= FLUSH_VEC;
            cnt      <= 16'h0000;
            ctl.busy <= 1'b0;
            ctl.done <= 1'b0;
            ctl.pass <= 1'b0;
        end else begin
            ctl.done <= 1'b0;
            cnt      <= cnt + 16'd1;
            case (state)
                IDLE: begin
                    cnt <= 16'h0000;
                    if (ctl.start && !ctl.abort) begin
                        state    <= FLUSH;
                        misr     <= 16'h0000;
                        lfsr     <= SEED_NZ;
                        ctl.pass <= 1'b0;
                        ctl.busy <= 1'b1;
`ifdef S386_BIST_SIGOUT_EN
                        ctl.sig  <= 16'h0000;
`endif
                    end
                end
                FLUSH: if (cnt == FLUSH_LAST) begin
                    state  <= RUN;
                    cnt    <= 16'h0000;
                    cut_in <= lfsr;
                    lfsr   <= lfsr_nxt;
                end
                RUN: begin
                    misr <= misr_nxt;
                    if (cnt == RUN_LAST) begin
                        state  <= CMP;
                        cnt    <= 16'h0000;
                        cut_in <= FLUSH_VEC;
                    end else begin
                        cut_in <= lfsr;
                        lfsr   <= lfsr_nxt;
                    end
                end
                CMP: begin
                    state    <= DONE;
                    cnt      <= 16'h0000;
                    ctl.pass <= (misr == GOLDEN);
                    ctl.busy <= 1'b0;
                    ctl.done <= 1'b1;
`ifdef S386_BIST_SIGOUT_EN
                    ctl.sig  <= misr;
`endif
                end
                default: begin
                    state <= IDLE;
                    cnt   <= 16'h0000;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_s386_bist_ctrl.sv
// tb_s386_bist_ctrl: directed scoreboard bench for s386_bist_ctrl (three parameterisations,
// one with a combinational stand-in for the s386 core).
module tb_s386_bist_ctrl;
    function automatic logic [6:0] core_f(input logic [6:0] x);
        return {x[2:0], x[6:3]} ^ 7'h5A;
    endfunction

    function automatic logic [15:0] sig_model(input int n, input logic [6:0] co, input bit core);
        logic [15:0] m;
        logic [6:0]  q;
        logic [6:0]  o;
        m = 16'h0000;
        q = 7'h01;
        for (int k = 0; k < n; k++) begin
            o = core ? core_f(q) : co;
            m = {m[14:0], 1'b0} ^ (m[15] ? 16'h1021 : 16'h0000) ^ {9'b0, o};
            q = {q[5:0], q[6] ^ q[5]};
        end
        return m;
    endfunction

    localparam logic [15:0] GOLD_C = sig_model(127, 7'h00, 1'b1);

    typedef struct packed {logic pass; logic [15:0] sig;} exp_t;

    logic       CK = 1'b0, RN = 1'b0, start = 1'b0, abort = 1'b0;
    logic [1:0] sel = 2'd0;
    logic [6:0] co_a = 7'h00, cut_in_a, cut_in_b, cut_in_c, co_c;
    logic       obs_busy, obs_done, obs_pass;
    logic [6:0] obs_cut;
    int         n_chk = 0, n_fail = 0;
    exp_t       sbq[$];
    logic [6:0] pq[$];
    logic [6:0] tbl[8] = '{7'h01, 7'h02, 7'h04, 7'h08, 7'h10, 7'h20, 7'h41, 7'h03};

    s386_bist_ctrl_if ifa();
    s386_bist_ctrl_if ifb();
    s386_bist_ctrl_if ifc();

    assign ifa.start = start & (sel == 2'd0);
    assign ifb.start = start & (sel == 2'd1);
    assign ifc.start = start & (sel == 2'd2);
    assign ifa.abort = abort & (sel == 2'd0);
    assign ifb.abort = abort & (sel == 2'd1);
    assign ifc.abort = abort & (sel == 2'd2);
    assign co_c      = core_f(cut_in_c);

    s386_bist_ctrl #(.NPAT(16), .FLUSH_CYC(8), .GOLDEN(16'h0000)) u_a (
        .CK(CK), .RN(RN), .ctl(ifa), .cut_in(cut_in_a), .cut_out(co_a));
    s386_bist_ctrl #(.NPAT(1), .FLUSH_CYC(8), .GOLDEN(16'h0000)) u_b (
        .CK(CK), .RN(RN), .ctl(ifb), .cut_in(cut_in_b), .cut_out(7'h01));
    s386_bist_ctrl #(.NPAT(127), .FLUSH_CYC(8), .GOLDEN(GOLD_C)) u_c (
        .CK(CK), .RN(RN), .ctl(ifc), .cut_in(cut_in_c), .cut_out(co_c));

    assign obs_busy = (sel == 2'd0) ? ifa.busy : (sel == 2'd1) ? ifb.busy : ifc.busy;
    assign obs_done = (sel == 2'd0) ? ifa.done : (sel == 2'd1) ? ifb.done : ifc.done;
    assign obs_pass = (sel == 2'd0) ? ifa.pass : (sel == 2'd1) ? ifb.pass : ifc.pass;
    assign obs_cut  = (sel == 2'd0) ? cut_in_a : (sel == 2'd1) ? cut_in_b : cut_in_c;
`ifdef S386_BIST_SIGOUT_EN
    logic [15:0] obs_sig;
    assign obs_sig = (sel == 2'd0) ? ifa.sig : (sel == 2'd1) ? ifb.sig : ifc.sig;
`endif

    always #5 CK = ~CK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // full test on the selected DUT; race>=0 pulses start at that busy cycle
    task automatic run(input int fl, input int np, input int race, input logic [15:0] esig,
                       input logic [15:0] gold);
        int   bc, dn;
        logic [6:0] q;
        exp_t e;
        bc = 0;
        dn = 0;
        q  = 7'h01;
        for (int k = 0; k < np; k++) begin
            pq.push_back(k < 8 ? tbl[k] : q);
            q = {q[5:0], q[6] ^ q[5]};
        end
        sbq.push_back('{pass: (esig == gold), sig: esig});
        start = 1'b1;
        @(negedge CK);
        start = 1'b0;
        for (int c = 0; c < fl + np + 8; c++) begin
            if (obs_busy) bc++;
            if (c < fl) chk("flush_vec", 32'(obs_cut), 32'h00);
            else if (c < fl + np && pq.size() > 0) chk("run_pattern", 32'(obs_cut), 32'(pq.pop_front()));
            if (obs_done) begin
                dn++;
                if (sbq.size() > 0) begin
                    e = sbq.pop_front();
                    chk("pass", 32'(obs_pass), 32'(e.pass));
`ifdef S386_BIST_SIGOUT_EN
                    chk("sig", 32'(obs_sig), 32'(e.sig));
`endif
                end
            end
            start = (c == race);
            @(negedge CK);
        end
        start = 1'b0;
        chk("busy_cycles", bc, fl + np + 1);
        chk("done_pulses", dn, 1);
    endtask

    initial begin
        int dn;
        #1;
        chk("rst_busy", 32'(obs_busy), 0);
        chk("rst_done", 32'(obs_done), 0);
        chk("rst_pass", 32'(obs_pass), 0);
        chk("rst_cut_in", 32'(obs_cut), 32'h00);
        @(negedge CK);
        RN = 1'b1;
        @(negedge CK);
        run(8, 16, -1, sig_model(16, 7'h00, 1'b0), 16'h0000);
        co_a = 7'h2A;
        run(8, 16, 13, sig_model(16, 7'h2A, 1'b0), 16'h0000);
        co_a = 7'h00;
        // abort at RUN cycle 3
        start = 1'b1;
        @(negedge CK);
        start = 1'b0;
        repeat (11) @(negedge CK);
        abort = 1'b1;
        @(negedge CK);
        abort = 1'b0;
        chk("abort_busy", 32'(obs_busy), 0);
        chk("abort_done", 32'(obs_done), 0);
        chk("abort_pass", 32'(obs_pass), 0);
        chk("abort_cut_in", 32'(obs_cut), 32'h00);
        dn = 0;
        repeat (30) begin
            if (obs_done || obs_busy) dn++;
            @(negedge CK);
        end
        chk("abort_quiet", dn, 0);
        start = 1'b1;
        abort = 1'b1;
        @(negedge CK);
        start = 1'b0;
        abort = 1'b0;
        chk("start_abort_idle", 32'(obs_busy), 0);
        @(negedge CK);
        chk("start_abort_idle2", 32'(obs_busy), 0);
        // asynchronous reset mid-RUN
        start = 1'b1;
        @(negedge CK);
        start = 1'b0;
        repeat (12) @(negedge CK);
        chk("pre_rst_busy", 32'(obs_busy), 1);
        #2 RN = 1'b0;
        #1;
        chk("mid_rst_busy", 32'(obs_busy), 0);
        chk("mid_rst_done", 32'(obs_done), 0);
        chk("mid_rst_pass", 32'(obs_pass), 0);
        chk("mid_rst_cut_in", 32'(obs_cut), 32'h00);
        @(negedge CK);
        RN = 1'b1;
        dn = 0;
        repeat (30) begin
            if (obs_done || obs_busy) dn++;
            @(negedge CK);
        end
        chk("rst_quiet", dn, 0);
        sel = 2'd1;
        @(negedge CK);
        run(8, 1, -1, 16'h0001, 16'h0000);
        sel = 2'd2;
        @(negedge CK);
        run(8, 127, -1, sig_model(127, 7'h00, 1'b1), GOLD_C);
        run(8, 127, -1, sig_model(127, 7'h00, 1'b1), GOLD_C);
        chk("sb_empty", sbq.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
